trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Sequences machine-mode trap entry and return around the CSR register file.
- Evaluates pending interrupts (mip & mie, gated by global MIE) and ecall requests, drains the pipeline, then issues one-cycle int_action/ret_action strobes with int_code, hw_int and trap_pc to the CSR file.
- Redirects fetch to the mtvec handler or to mepc.
- Sits between the core pipeline, the CSR file and the PC mux.

Parameters:
- DRAIN_TIMEOUT, 16: maximum cycles spent in DRAIN before the trap is forced without pipe_drained.
- CNT_W, 5: width of the drain counter; must satisfy 2^CNT_W > DRAIN_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mip_i  in  32  pending bits from the CSR file
- mie_i  in  32  enable bits from the CSR file
- mie_global_i  in  1  mstatus.MIE
- mtvec_i  in  32  trap vector CSR
- mepc_i  in  32  exception PC CSR
- pc_i  in  32  PC of the oldest un-retired instruction
- ecall_i  in  1  ecall at commit; valid only in IDLE
- mret_i  in  1  mret at commit; valid only in IDLE
- pipe_drained_i  in  1  pipeline empty acknowledge
- drain_req_o  out  1  request the pipeline to stop issue and drain
- stall_o  out  1  freeze fetch/commit
- int_action_o  out  1  one-cycle trap-entry strobe to the CSR file
- ret_action_o  out  1  one-cycle mret strobe to the CSR file
- hw_int_o  out  1  1 = interrupt, 0 = exception
- int_code_o  out  5  cause code
- trap_pc_o  out  32  PC for mepc capture (drives current_pc)
- redirect_valid_o  out  1  one-cycle PC redirect strobe
- redirect_pc_o  out  32  redirect target

Behaviour:
- Reset:
  - Asynchronous, active-high; clock is clk.
  - Reset forces state IDLE and clears the drain counter.
  - All outputs are 0 during and after reset.
  - Reset asserted mid-sequence aborts the sequence immediately; no strobe is issued.
- States: IDLE, DRAIN, TAKE, REDIRECT, RET.
- Interrupt selection:
  - irq_vec = mip_i & mie_i & {20'b0, 1<<11 | 1<<7 | 1<<3}.
  - An interrupt is pending when mie_global_i && |irq_vec.
  - Fixed priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
- IDLE, arbitration priority ecall_i > mret_i > pending interrupt:
  - ecall: latch code 11, hw_int 0, trap_pc = pc_i, go to TAKE. No drain is needed; the instruction is at commit.
  - mret: go to RET.
  - Interrupt: latch the winning code with hw_int 1, assert drain_req_o and stall_o, clear the counter, go to DRAIN. Code and hw_int are frozen from this point; later changes to mip/mie do not alter or cancel the trap.
- DRAIN:
  - drain_req_o and stall_o stay high; the counter increments each cycle.
  - On pipe_drained_i, or counter == DRAIN_TIMEOUT-1, latch trap_pc = pc_i and go to TAKE.
- TAKE:
  - Exactly one cycle.
  - int_action_o = 1; int_code_o, hw_int_o and trap_pc_o hold the latched values; stall_o = 1.
  - The CSR file saves MIE into MPIE, clears MIE, and writes mepc and mcause on this edge.
  - Next state: REDIRECT.
- REDIRECT:
  - Exactly one cycle; redirect_valid_o = 1, stall_o = 1.
  - redirect_pc_o = {mtvec_i[31:2], 2'b00} by default (see Optional Feature).
  - Next state: IDLE.
  - The first IDLE cycle sees mie_global_i = 0, so no back-to-back interrupt is taken.
- RET:
  - Exactly one cycle.
  - ret_action_o = 1, redirect_valid_o = 1, redirect_pc_o = mepc_i, stall_o = 1.
  - Next state: IDLE.
- Strobe and output rules:
  - int_action_o, ret_action_o and redirect_valid_o are never high except in the states listed above.
  - int_action_o and ret_action_o are never high together.
  - ecall_i and mret_i outside IDLE are ignored; stall_o guarantees they are held.
  - Outputs are registered; int_code_o, hw_int_o and trap_pc_o hold their last latched values between traps.
- Address arithmetic wraps modulo 2^32.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: when mtvec_i[1:0] == 2'b01 and hw_int latched = 1, redirect_pc_o = {mtvec_i[31:2], 2'b00} + (int_code << 2).
  - Exceptions and mtvec_i[1:0] ∈ {00, 10, 11} use the base address.
- Undefined: redirect_pc_o is always the base address, regardless of the mtvec mode bits.

Test Plan:
- MTI pending:
  - Stimulus: mie_global=1, mie=0x80, mip=0x80; pipe_drained asserted 3 cycles later; pc_i=0x100, mtvec=0x200.
  - Response: drain_req high for the drain; one-cycle int_action with code 7, hw_int 1, trap_pc 0x100; next cycle redirect to 0x200.
- Simultaneous interrupts:
  - Stimulus: mip=mie=0x888.
  - Response: code 11 taken.
  - After the trap, with mie_global still 0, no further int_action occurs.
- Ecall against pending interrupt:
  - Stimulus: ecall_i=1 with an interrupt pending, pc_i=0x40.
  - Response: next cycle int_action with code 11, hw_int 0, trap_pc 0x40; drain_req stays 0.
- mret:
  - Stimulus: mret_i=1, mepc=0x1234.
  - Response: next cycle ret_action=1, redirect_valid=1, redirect_pc=0x1234; int_action stays 0.
- Drain timeout and mid-drain changes:
  - Stimulus: DRAIN_TIMEOUT=16, pipe_drained never asserted.
  - Response: TAKE exactly 16 cycles after DRAIN entry.
  - Dropping mip mid-drain still yields int_action with the frozen code.
- Reset and vectored mode:
  - Stimulus: reset asserted during DRAIN; then, with TRAP_VECTORED_EN defined, mtvec=0x201 and MEI taken.
  - Response: reset gives all outputs 0 and IDLE with no strobe; the vectored trap redirects to 0x22C.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/return sequencer between pipeline, CSR file and PC mux; vectored mode under TRAP_VECTORED_EN.
// Latency: registered outputs, strobes one cycle after the deciding edge; ecall/mret 1 cycle, interrupts after drain.
// Backpressure: holds stall_o for the whole sequence; waits up to DRAIN_TIMEOUT cycles for pipe_drained_i.
module trap_sequencer #(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mip_i,
  input  logic [31:0] mie_i,
  input  logic        mie_global_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        pipe_drained_i,
  output logic        drain_req_o,
  output logic        stall_o,
  output logic        int_action_o,
  output logic        ret_action_o,
  output logic        hw_int_o,
  output logic [4:0]  int_code_o,
  output logic [31:0] trap_pc_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    TAKE,
    REDIRECT,
    RET
  } state_t;

  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [4:0]       code_q, code_nxt;
  logic             hw_q, hw_nxt;
  logic             latch_pc;

  logic [31:0] irq_vec;
  logic        irq_pend;
  logic [4:0]  irq_code;
  logic [31:0] base_pc;
  logic [31:0] vec_pc;

  assign irq_vec  = mip_i & mie_i & IRQ_MASK;
  assign irq_pend = mie_global_i && (|irq_vec);

  // Fixed priority MEI > MSI > MTI.
  always_comb begin
    irq_code = 5'd7;
    if (irq_vec[11])
      irq_code = 5'd11;
    else if (irq_vec[3])
      irq_code = 5'd3;
  end

  assign base_pc = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Cause fields already hold the values loaded on TAKE entry.
  always_comb begin
    vec_pc = base_pc;
    if (mtvec_i[1:0] == 2'b01 && hw_int_o)
      vec_pc = base_pc + {25'b0, int_code_o, 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = ^mtvec_i[1:0];
  assign vec_pc      = base_pc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      hw_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      code_q  <= code_nxt;
      hw_q    <= hw_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    code_nxt  = code_q;
    hw_nxt    = hw_q;
    latch_pc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ecall_i) begin
          state_nxt = TAKE;
          code_nxt  = 5'd11;
          hw_nxt    = 1'b0;
          latch_pc  = 1'b1;
        end else if (mret_i) begin
          state_nxt = RET;
        end else if (irq_pend) begin
          state_nxt = DRAIN;
          code_nxt  = irq_code;
          hw_nxt    = 1'b1;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt_q + CNT_W'(1);
        if (pipe_drained_i || cnt_q == CNT_LAST) begin
          state_nxt = TAKE;
          latch_pc  = 1'b1;
        end
      end
      TAKE:     state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      RET:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_req_o      <= 1'b0;
      stall_o          <= 1'b0;
      int_action_o     <= 1'b0;
      ret_action_o     <= 1'b0;
      hw_int_o         <= 1'b0;
      int_code_o       <= '0;
      trap_pc_o        <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      drain_req_o      <= (state_nxt == DRAIN);
      stall_o          <= (state_nxt != IDLE);
      int_action_o     <= (state_nxt == TAKE);
      ret_action_o     <= (state_nxt == RET);
      redirect_valid_o <= (state_nxt == REDIRECT) || (state_nxt == RET);
      if (latch_pc) begin
        trap_pc_o  <= pc_i;
        int_code_o <= code_nxt;
        hw_int_o   <= hw_nxt;
      end
      if (state_nxt == RET)
        redirect_pc_o <= mepc_i;
      else if (state_nxt == REDIRECT)
        redirect_pc_o <= vec_pc;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: one linear sequence with immediate-assertion checks.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mip, mie, mtvec, mepc, pc;
  logic        mie_global, ecall, mret, pipe_drained;
  logic        drain_req, stall, int_action, ret_action, hw_int, redirect_valid;
  logic [4:0]  int_code;
  logic [31:0] trap_pc, redirect_pc;

  int vectors = 0;
  int errors  = 0;

  trap_sequencer #(.DRAIN_TIMEOUT(16), .CNT_W(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .mip_i            (mip),
    .mie_i            (mie),
    .mie_global_i     (mie_global),
    .mtvec_i          (mtvec),
    .mepc_i           (mepc),
    .pc_i             (pc),
    .ecall_i          (ecall),
    .mret_i           (mret),
    .pipe_drained_i   (pipe_drained),
    .drain_req_o      (drain_req),
    .stall_o          (stall),
    .int_action_o     (int_action),
    .ret_action_o     (ret_action),
    .hw_int_o         (hw_int),
    .int_code_o       (int_code),
    .trap_pc_o        (trap_pc),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_drain"}, 32'(drain_req), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_int"}, 32'(int_action), 32'd0);
    check({tag, "_ret"}, 32'(ret_action), 32'd0);
    check({tag, "_redir"}, 32'(redirect_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] vec_exp;
    reset = 1'b1;
    mip = '0; mie = '0; mtvec = 32'h200; mepc = '0; pc = 32'h100;
    mie_global = 1'b0; ecall = 1'b0; mret = 1'b0; pipe_drained = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    check("reset_code", 32'(int_code), 32'd0);
    check("reset_tpc", trap_pc, 32'd0);
    check("reset_rpc", redirect_pc, 32'd0);
    reset = 1'b0;
    tick();
    check_quiet("idle");

    // MTI, drained on the third drain cycle
    mie_global = 1'b1; mie = 32'h80; mip = 32'h80;
    tick();
    check("mti_drain0", 32'(drain_req), 32'd1);
    check("mti_stall0", 32'(stall), 32'd1);
    check("mti_noint0", 32'(int_action), 32'd0);
    tick();
    tick();
    check("mti_drain2", 32'(drain_req), 32'd1);
    pipe_drained = 1'b1;
    tick();
    check("mti_int", 32'(int_action), 32'd1);
    check("mti_code", 32'(int_code), 32'd7);
    check("mti_hw", 32'(hw_int), 32'd1);
    check("mti_tpc", trap_pc, 32'h100);
    check("mti_drain_off", 32'(drain_req), 32'd0);
    check("mti_stall_take", 32'(stall), 32'd1);
    pipe_drained = 1'b0; mie_global = 1'b0;
    tick();
    check("mti_redir", 32'(redirect_valid), 32'd1);
    check("mti_rpc", redirect_pc, 32'h200);
    check("mti_int_off", 32'(int_action), 32'd0);
    tick();
    check_quiet("mti_idle");
    check("mti_code_hold", 32'(int_code), 32'd7);

    // Simultaneous MEI/MSI/MTI: MEI wins, no retrigger with MIE cleared
    mip = 32'h888; mie = 32'h888; mie_global = 1'b1;
    tick();
    check("sim_drain", 32'(drain_req), 32'd1);
    pipe_drained = 1'b1;
    tick();
    check("sim_int", 32'(int_action), 32'd1);
    check("sim_code", 32'(int_code), 32'd11);
    pipe_drained = 1'b0; mie_global = 1'b0;
    tick();
    tick();
    tick();
    check_quiet("sim_after");

    // MSI beats MTI
    mip = 32'h88; mie = 32'h88; mie_global = 1'b1;
    tick();
    pipe_drained = 1'b1;
    tick();
    check("msi_code", 32'(int_code), 32'd3);
    pipe_drained = 1'b0; mie_global = 1'b0;
    tick();
    tick();

    // ecall beats a pending interrupt; no drain
    mip = 32'h80; mie = 32'h80; mie_global = 1'b1; ecall = 1'b1; pc = 32'h40;
    tick();
    check("ecall_int", 32'(int_action), 32'd1);
    check("ecall_code", 32'(int_code), 32'd11);
    check("ecall_hw", 32'(hw_int), 32'd0);
    check("ecall_tpc", trap_pc, 32'h40);
    check("ecall_nodrain", 32'(drain_req), 32'd0);
    ecall = 1'b0; mie_global = 1'b0; mtvec = 32'h201;
    tick();
    check("ecall_redir", 32'(redirect_valid), 32'd1);
    check("ecall_rpc_base", redirect_pc, 32'h200);
    tick();
    mtvec = 32'h200;

    // mret
    mret = 1'b1; mepc = 32'h1234;
    tick();
    check("mret_ret", 32'(ret_action), 32'd1);
    check("mret_redir", 32'(redirect_valid), 32'd1);
    check("mret_rpc", redirect_pc, 32'h1234);
    check("mret_noint", 32'(int_action), 32'd0);
    check("mret_stall", 32'(stall), 32'd1);
    mret = 1'b0;
    tick();
    check_quiet("mret_idle");

    // Drain timeout, mip dropped mid-drain, pc moves before the forced take
    mip = 32'h8; mie = 32'h8; mie_global = 1'b1; pc = 32'h300;
    tick();
    check("to_drain0", 32'(drain_req), 32'd1);
    mip = 32'h0; pc = 32'h304;
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("to_wait%0d", i), 32'(int_action), 32'd0);
    end
    check("to_drain15", 32'(drain_req), 32'd1);
    tick();
    check("to_int", 32'(int_action), 32'd1);
    check("to_code", 32'(int_code), 32'd3);
    check("to_tpc", trap_pc, 32'h304);
    mie_global = 1'b0;
    tick();
    tick();

    // Reset during DRAIN aborts with no strobe
    mip = 32'h800; mie = 32'h800; mie_global = 1'b1;
    tick();
    tick();
    check("rst_pre_drain", 32'(drain_req), 32'd1);
    reset = 1'b1;
    #1;
    check_quiet("rst_async");
    check("rst_code", 32'(int_code), 32'd0);
    tick();
    check("rst_hold_int", 32'(int_action), 32'd0);
    reset = 1'b0; mie_global = 1'b0;
    tick();
    check_quiet("rst_idle");

    // MEI with mtvec in vectored mode
    mtvec = 32'h201; mie_global = 1'b1;
    tick();
    pipe_drained = 1'b1;
    tick();
    check("vec_int", 32'(int_action), 32'd1);
    check("vec_code", 32'(int_code), 32'd11);
    pipe_drained = 1'b0; mie_global = 1'b0;
    tick();
`ifdef TRAP_VECTORED_EN
    vec_exp = 32'h22C;
`else
    vec_exp = 32'h200;
`endif
    check("vec_redir", 32'(redirect_valid), 32'd1);
    check("vec_rpc", redirect_pc, vec_exp);
    tick();
    check_quiet("vec_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
